// File: rtl/score_pkg.sv
// ============================================================================
// score_pkg : shared geometry, widths, FSM encoding and BCD helper
// Rev 1.0
// ============================================================================
`default_nettype none

package score_pkg;

  localparam int BMP_W      = 120;
  localparam int BMP_H      = 48;
  localparam int GLYPH_W    = 24;
  localparam int GLYPH_H    = 48;
  localparam int GLYPH_BITS = GLYPH_W * GLYPH_H;
  localparam int NUM_DIGITS = 5;

  localparam int WR_AW   = 13;
  localparam int FONT_AW = 14;
  localparam int SCORE_W = 17;
  localparam int BCD_W   = 4 * NUM_DIGITS;
  localparam int PIXELS  = BMP_W * BMP_H;

  localparam logic [4:0]       COL_LAST = 5'(GLYPH_W - 1);
  localparam logic [2:0]       DIG_LAST = 3'(NUM_DIGITS - 1);
  localparam logic [WR_AW-1:0] LIN_LAST = WR_AW'(PIXELS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CONVERT = 3'd1,
    S_DRAW    = 3'd2,
    S_FLUSH   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  // Add-3 correction on every BCD nibble that is 5 or more, ahead of a shift
  function automatic logic [BCD_W-1:0] dabble(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
// ============================================================================
// bin2bcd_seq : sequential double-dabble, one bit per clock, 17 shifts total
// Rev 1.0
// ============================================================================
`default_nettype none

module bin2bcd_seq
  import score_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [SCORE_W-1:0] bin,
  output logic [BCD_W-1:0]   bcd,
  output logic               done
);

  logic [SCORE_W-1:0] sh_q, sh_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d, adj;
  logic [4:0]         cnt_q, cnt_d;

  always_comb begin
    sh_d  = sh_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    adj   = dabble(bcd_q);
    // The start edge already performs the first shift (add-3 on zero is a no-op)
    if (start) begin
      bcd_d = {{(BCD_W-1){1'b0}}, bin[SCORE_W-1]};
      sh_d  = bin << 1;
      cnt_d = 5'(SCORE_W - 1);
    end else if (cnt_q != 5'd0) begin
      bcd_d = {adj[BCD_W-2:0], sh_q[SCORE_W-1]};
      sh_d  = sh_q << 1;
      cnt_d = cnt_q - 5'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q  <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
    end
  end

  assign bcd  = bcd_q;
  assign done = (cnt_q == 5'd1);

endmodule

`default_nettype wire

// File: rtl/score_bitmap_writer.sv
// ============================================================================
// score_bitmap_writer : renders a saturated score as 5 digits into the bitmap
// Rev 1.0
// ============================================================================
`default_nettype none

module score_bitmap_writer
  import score_pkg::*;
#(
  parameter int BLANK_LZ  = 1,
  parameter int SCORE_MAX = 99999
) (
  input  logic               iVGA_CLK,
  input  logic               iRST,
  input  logic [SCORE_W-1:0] iSCORE,
  input  logic               iUPDATE,
  output logic               oBUSY,
  output logic               oDONE,
  output logic [FONT_AW-1:0] oFONT_ADDR,
  input  logic               iFONT_Q,
  output logic [WR_AW-1:0]   oWR_ADDR,
  output logic               oWR_DATA,
  output logic               oWR_EN
);

  localparam logic [SCORE_W-1:0] SAT = SCORE_W'(SCORE_MAX);

  state_t             state_q, state_d;
  logic               pending_q, pending_d;
  logic [SCORE_W-1:0] pend_score_q, pend_score_d;
  logic [4:0]         col_q, col_d;
  logic [2:0]         digit_q, digit_d;
  logic [5:0]         row_q, row_d;
  logic [WR_AW-1:0]   lin_q, lin_d;
  logic               wr_en_q, wr_en_d;
  logic [WR_AW-1:0]   wr_addr_q, wr_addr_d;
  logic               blank_q, blank_d;

  logic [SCORE_W-1:0]    sat_score, conv_bin;
  logic                  conv_start, conv_done;
  logic [BCD_W-1:0]      bcd;
  logic [3:0]            glyph;
  logic [NUM_DIGITS-1:0] lz;
  logic                  digit_blank;

  assign sat_score = (iSCORE > SAT) ? SAT : iSCORE;

  bin2bcd_seq u_bcd (
    .clk   (iVGA_CLK),
    .rst   (iRST),
    .start (conv_start),
    .bin   (conv_bin),
    .bcd   (bcd),
    .done  (conv_done)
  );

  // Digit 0 is the leftmost (most significant); lz marks leading zeros only
  always_comb begin
    lz    = '0;
    glyph = '0;
    lz[0] = (bcd[BCD_W-1 -: 4] == 4'd0);
    for (int i = 1; i < NUM_DIGITS - 1; i++) begin
      lz[i] = lz[i-1] && (bcd[4*(NUM_DIGITS-1-i) +: 4] == 4'd0);
    end
    digit_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_q == 3'(i)) begin
        glyph       = bcd[4*(NUM_DIGITS-1-i) +: 4];
        digit_blank = (BLANK_LZ != 0) && lz[i];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    pend_score_d = pend_score_q;
    conv_start   = 1'b0;
    conv_bin     = sat_score;
    col_d        = '0;
    digit_d      = '0;
    row_d        = '0;
    lin_d        = '0;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    blank_d      = blank_q;

    case (state_q)
      S_IDLE: begin
        if (iUPDATE) begin
          conv_start = 1'b1;
          state_d    = S_CONVERT;
        end
      end
      S_CONVERT: begin
        if (conv_done) state_d = S_DRAW;
      end
      S_DRAW: begin
        wr_en_d   = 1'b1;
        wr_addr_d = lin_q;
        blank_d   = digit_blank;
        lin_d     = lin_q + 1'b1;
        col_d     = col_q + 5'd1;
        digit_d   = digit_q;
        row_d     = row_q;
        if (col_q == COL_LAST) begin
          col_d = '0;
          if (digit_q == DIG_LAST) begin
            digit_d = '0;
            row_d   = row_q + 6'd1;
          end else begin
            digit_d = digit_q + 3'd1;
          end
        end
        if (lin_q == LIN_LAST) begin
          state_d = S_FLUSH;
          lin_d   = '0;
          col_d   = '0;
          digit_d = '0;
          row_d   = '0;
        end
      end
      S_FLUSH: state_d = S_DONE;
      S_DONE: begin
        // A request arriving now is newer than anything pending
        if (iUPDATE || pending_q) begin
          conv_start = 1'b1;
          conv_bin   = iUPDATE ? sat_score : pend_score_q;
          pending_d  = 1'b0;
          state_d    = S_CONVERT;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (iUPDATE && (state_q == S_CONVERT || state_q == S_DRAW || state_q == S_FLUSH)) begin
      pending_d    = 1'b1;
      pend_score_d = sat_score;
    end
  end

  always_ff @(posedge iVGA_CLK or posedge iRST) begin
    if (iRST) begin
      state_q      <= S_IDLE;
      pending_q    <= 1'b0;
      pend_score_q <= '0;
      col_q        <= '0;
      digit_q      <= '0;
      row_q        <= '0;
      lin_q        <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      blank_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      pend_score_q <= pend_score_d;
      col_q        <= col_d;
      digit_q      <= digit_d;
      row_q        <= row_d;
      lin_q        <= lin_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      blank_q      <= blank_d;
    end
  end

  // ROM output lines up with the delayed write address one cycle later
  assign oFONT_ADDR = (state_q == S_DRAW)
                    ? FONT_AW'(glyph) * FONT_AW'(GLYPH_BITS)
                      + FONT_AW'(row_q) * FONT_AW'(GLYPH_W) + FONT_AW'(col_q)
                    : '0;
  assign oWR_EN   = wr_en_q;
  assign oWR_ADDR = wr_addr_q;
  assign oWR_DATA = wr_en_q & iFONT_Q & ~blank_q;
  assign oBUSY    = (state_q != S_IDLE);
  assign oDONE    = (state_q == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_score_bitmap_writer.sv
// ============================================================================
// tb_score_bitmap_writer : scoreboard bench with a hashed registered font ROM
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_score_bitmap_writer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, upd, upd0;
  logic [16:0] score, score0;
  logic        busy, done, wr_en, wr_data, font_q;
  logic [13:0] font_addr;
  logic [12:0] wr_addr;
  logic        busy0, done0, wr_en0, wr_data0, font_q0;
  logic [13:0] font_addr0;
  logic [12:0] wr_addr0;

  score_bitmap_writer #(.BLANK_LZ(1)) dut (
    .iVGA_CLK(clk), .iRST(rst), .iSCORE(score), .iUPDATE(upd),
    .oBUSY(busy), .oDONE(done), .oFONT_ADDR(font_addr), .iFONT_Q(font_q),
    .oWR_ADDR(wr_addr), .oWR_DATA(wr_data), .oWR_EN(wr_en));

  score_bitmap_writer #(.BLANK_LZ(0)) dut0 (
    .iVGA_CLK(clk), .iRST(rst), .iSCORE(score0), .iUPDATE(upd0),
    .oBUSY(busy0), .oDONE(done0), .oFONT_ADDR(font_addr0), .iFONT_Q(font_q0),
    .oWR_ADDR(wr_addr0), .oWR_DATA(wr_data0), .oWR_EN(wr_en0));

  function automatic bit font_bit(input int a);
    logic [31:0] h;
    h = a * 32'h9E3779B1;
    h = h ^ (h >> 15);
    return h[20];
  endfunction

  always @(posedge clk) begin
    font_q  <= font_bit(int'(font_addr));
    font_q0 <= font_bit(int'(font_addr0));
  end

  typedef struct packed { logic [12:0] addr; logic data; } wr_t;
  typedef struct { int score; logic [39:0] txt; } vec_t;

  wr_t  sb[$];
  bit   bmp0 [5760];
  int   cyc = 0, n_cmp = 0, n_fail = 0;
  int   wr_n, first_wr, last_wr, done_cyc, n_done, idle_n, wr0_n, k;
  bit   seen_done, seen_done0, ok;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Golden pixel: space = blanked digit, otherwise the glyph for that character
  function automatic bit exp_pix(input logic [39:0] txt, input int a);
    int y, x, g, c;
    logic [7:0] ch;
    y = a / 120; x = a % 120; g = x / 24; c = x % 24;
    ch = txt[8*(4-g) +: 8];
    if (ch == " ") return 1'b0;
    return font_bit((int'(ch) - 48) * 1152 + y * 24 + c);
  endfunction

  task automatic expect_render(input logic [39:0] txt);
    for (int a = 0; a < 5760; a++) sb.push_back('{addr: 13'(a), data: exp_pix(txt, a)});
  endtask

  task automatic tick();
    wr_t e;
    @(negedge clk);
    cyc++;
    if (!busy) idle_n++;
    if (wr_en) begin
      if (sb.size() == 0) chk("unexpected_write_addr", int'(wr_addr), -1);
      else begin
        e = sb.pop_front();
        chk("wr_addr", int'(wr_addr), int'(e.addr));
        chk("wr_data", int'(wr_data), int'(e.data));
      end
      if (wr_n == 0) first_wr = cyc;
      last_wr = cyc;
      wr_n++;
    end
    if (done) begin seen_done = 1'b1; done_cyc = cyc; n_done++; end
    if (wr_en0) begin bmp0[wr_addr0] = wr_data0; wr0_n++; end
    if (done0) seen_done0 = 1'b1;
  endtask

  task automatic start_render(input int s);
    wr_n = 0; seen_done = 1'b0;
    score = 17'(s); upd = 1'b1; k = cyc;
    tick();
    upd = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!seen_done && n < budget) begin tick(); n++; end
    if (!seen_done) chk("done_timeout", 0, 1);
  endtask

  task automatic render_check(input int k0);
    chk("first_wr_latency", first_wr - k0, 18);
    chk("last_wr_latency", last_wr - k0, 5777);
    chk("done_latency", done_cyc - k0, 5778);
    chk("write_count", wr_n, 5760);
  endtask

  vec_t vecs [5];
  int   d, bad;

  initial begin
    vecs[0] = '{12345,  "12345"};
    vecs[1] = '{0,      "    0"};
    vecs[2] = '{123456, "99999"};
    vecs[3] = '{99999,  "99999"};
    vecs[4] = '{10000,  "10000"};

    rst = 1'b1; upd = 1'b0; upd0 = 1'b0; score = '0; score0 = '0;
    wr_n = 0; n_done = 0; idle_n = 0; wr0_n = 0; seen_done0 = 1'b0;
    repeat (3) tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_wr_data", int'(wr_data), 0);
    chk("rst_font_addr", int'(font_addr), 0);
    rst = 1'b0;
    tick();

    for (int v = 0; v < 5; v++) begin
      expect_render(vecs[v].txt);
      start_render(vecs[v].score);
      wait_done(6000);
      render_check(k);
      chk("sb_drained", sb.size(), 0);
      tick();
      chk("idle_after_done", int'(busy), 0);
    end

    // Two updates mid-render: latest wins, no IDLE gap, 42 never drawn
    expect_render("12345");
    n_done = 0;
    start_render(12345);
    d = k; idle_n = 0;
    repeat (100) tick();
    score = 17'd42; upd = 1'b1; tick(); upd = 1'b0;
    repeat (1000) tick();
    score = 17'd7; upd = 1'b1; expect_render("    7"); tick(); upd = 1'b0;
    wait_done(6000);
    render_check(d);
    d = done_cyc; wr_n = 0; seen_done = 1'b0;
    wait_done(6000);
    render_check(d);
    chk("pending_no_idle", idle_n, 0);
    repeat (20) tick();
    chk("pending_done_pulses", n_done, 2);
    chk("pending_sb_drained", sb.size(), 0);

    // Update landing exactly in the DONE cycle
    expect_render("  300");
    start_render(300);
    d = k; idle_n = 0;
    while (cyc < d + 5778) tick();
    chk("coincident_done_seen", int'(done), 1);
    chk("coincident_first_writes", wr_n, 5760);
    expect_render("   88");
    score = 17'd88; upd = 1'b1; d = cyc; wr_n = 0; seen_done = 1'b0;
    tick();
    upd = 1'b0;
    wait_done(6000);
    render_check(d);
    chk("coincident_no_idle", idle_n, 0);

    // Asynchronous reset at the 3000th write
    expect_render("12345");
    start_render(12345);
    while (wr_n < 3000 && cyc < k + 6000) tick();
    chk("reached_write_3000", wr_n, 3000);
    rst = 1'b1;
    #1;
    chk("async_rst_wr_en", int'(wr_en), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_wr_addr", int'(wr_addr), 0);
    chk("async_rst_font_addr", int'(font_addr), 0);
    sb.delete();
    repeat (2) tick();
    rst = 1'b0;
    tick();
    expect_render("  500");
    start_render(500);
    wait_done(6000);
    render_check(k);
    chk("after_rst_sb_drained", sb.size(), 0);

    // Leading-zero blanking disabled: five "0" glyphs
    for (int a = 0; a < 5760; a++) bmp0[a] = ~exp_pix("00000", a);
    wr0_n = 0; seen_done0 = 1'b0;
    score0 = 17'd0; upd0 = 1'b1; tick(); upd0 = 1'b0;
    for (int n = 0; n < 6000 && !seen_done0; n++) tick();
    chk("nolz_done_seen", int'(seen_done0), 1);
    chk("nolz_write_count", wr0_n, 5760);
    bad = 0;
    for (int a = 0; a < 5760; a++) if (bmp0[a] != exp_pix("00000", a)) bad++;
    chk("nolz_bitmap_bad_pixels", bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
